// File: rtl/btn_cap_pkg.sv
// Shared types and defaults for the button capture queue: FSM states,
// default parameter values and width helpers.
package btn_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } state_t;

  localparam int DEF_DATA_W        = 18;
  localparam int DEF_DEPTH         = 4;
  localparam int DEF_REPEAT_DELAY  = 25000000;
  localparam int DEF_REPEAT_PERIOD = 5000000;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Timer must hold the larger of the two limits minus one; floor at 2 keeps it >= 1 bit.
  function automatic int tmr_w(input int dly, input int per);
    int m;
    m = (dly > per) ? dly : per;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// First-word-fall-through FIFO: head entry is driven straight from storage,
// a push with the queue full is dropped and flagged unless a pop frees a slot.
module capture_fifo
  import btn_cap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       clr_ovf,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic                         full, empty;
  logic                         do_push, do_pop, drop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign rd_valid = ~empty;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/button_capture_queue.sv
// Captures the synchronized switch word on each button press (with hold
// auto-repeat) into a small FWFT queue drained by a single-cycle read strobe.
module button_capture_queue
  import btn_cap_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   button_in,
  input  logic [DATA_W-1:0]      sw_in,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            press_count
);

  localparam int TW = tmr_w(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int DLY_I = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int PER_I = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;
  localparam logic [TW-1:0] DLY_LAST = TW'(DLY_I);
  localparam logic [TW-1:0] PER_LAST = TW'(PER_I);
  localparam bit            RPT_EN   = (REPEAT_DELAY != 0);

  logic [DATA_W-1:0] sw_meta, sw_sync;
  logic              btn_q, rise;
  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic              push, inc;

  assign rise = button_in & ~btn_q;

  // btn_q resets high so a button held through reset needs a release first.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sw_meta     <= '0;
      sw_sync     <= '0;
      btn_q       <= 1'b1;
      state       <= IDLE;
      timer       <= '0;
      press_count <= '0;
    end else begin
      sw_meta     <= sw_in;
      sw_sync     <= sw_meta;
      btn_q       <= button_in;
      state       <= state_n;
      timer       <= timer_n;
      if (inc) press_count <= press_count + 16'd1;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    push    = 1'b0;
    inc     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          push    = 1'b1;
          inc     = 1'b1;
          state_n = HELD;
          timer_n = '0;
        end
      end
      HELD: begin
        if (!button_in) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (RPT_EN && timer == DLY_LAST) begin
          push    = 1'b1;
          state_n = REPEAT;
          timer_n = '0;
        end else if (RPT_EN) begin
          timer_n = timer + TW'(1);
        end
      end
      REPEAT: begin
        if (!button_in) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (timer == PER_LAST) begin
          push    = 1'b1;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  capture_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (push),
    .push_data (sw_sync),
    .pop       (rd_en),
    .clr_ovf   (clr_ovf),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .level     (level),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_button_capture_queue.sv
// Directed bench for button_capture_queue with DEPTH=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=4: hand sequences plus a table of per-cycle vectors.
module tb_button_capture_queue;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        button_in;
  logic [17:0] sw_in;
  logic        rd_en;
  logic        clr_ovf;
  logic [17:0] rd_data;
  logic        rd_valid;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] press_count;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        btn;
    logic [17:0] sw;
    logic        rd;
    logic        exp_valid;
    logic [17:0] exp_data;
    logic [2:0]  exp_level;
    logic        exp_ovf;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t tbl[13];

  button_capture_queue #(
    .DATA_W(18), .DEPTH(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .button_in   (button_in),
    .sw_in       (sw_in),
    .rd_en       (rd_en),
    .clr_ovf     (clr_ovf),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .level       (level),
    .overflow    (overflow),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(input logic b, input logic [17:0] s, input logic r, input logic c);
    button_in = b;
    sw_in     = s;
    rd_en     = r;
    clr_ovf   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rd_valid"}, 32'(rd_valid), 0);
    chk({tag, " rd_data"},  32'(rd_data), 0);
    chk({tag, " level"},    32'(level), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " press_count"}, 32'(press_count), 0);
  endtask

  initial begin
    n_reset = 1'b0; button_in = 1'b1; sw_in = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    #22;
    chk_reset("reset");
    @(posedge clk); #1;
    n_reset = 1'b1;

    // 1: button held through reset gives no capture; a fresh press does
    repeat (3) step(1, 18'h0, 0, 0);
    chk("t1 held valid", 32'(rd_valid), 0);
    chk("t1 held pc", 32'(press_count), 0);
    step(0, 18'h2A5A5, 0, 0);
    step(0, 18'h2A5A5, 0, 0);
    step(1, 18'h2A5A5, 0, 0);
    chk("t1 data", 32'(rd_data), 32'h2A5A5);
    chk("t1 level", 32'(level), 1);
    chk("t1 pc", 32'(press_count), 1);
    step(0, 18'h2A5A5, 1, 0);
    chk("t1 popped level", 32'(level), 0);

    // 2: hold -> pushes at rise, +10, +14, +18, +22; the last is dropped
    step(0, 18'h01000, 0, 0);
    step(0, 18'h01001, 0, 0);
    for (int k = 0; k <= 24; k++) begin
      step(1, 18'h01000 + 18'(k + 2), 0, 0);
      if (k == 0) begin
        chk("t2 rise level", 32'(level), 1);
        chk("t2 rise pc", 32'(press_count), 2);
      end
      if (k == 9)  chk("t2 pre-delay level", 32'(level), 1);
      if (k == 10) chk("t2 delay level", 32'(level), 2);
      if (k == 21) begin
        chk("t2 full level", 32'(level), 4);
        chk("t2 full ovf", 32'(overflow), 0);
      end
      if (k == 22) begin
        chk("t2 drop level", 32'(level), 4);
        chk("t2 drop ovf", 32'(overflow), 1);
        chk("t2 head", 32'(rd_data), 32'h01000);
      end
    end
    chk("t2 pc after repeats", 32'(press_count), 2);
    step(0, 18'h2BEEF, 0, 0);
    step(0, 18'h2BEEF, 0, 1);
    chk("t2 clr ovf", 32'(overflow), 0);

    // 3: full queue, rise with rd_en in the same cycle
    step(1, 18'h2BEEF, 1, 0);
    chk("t3 level", 32'(level), 4);
    chk("t3 ovf", 32'(overflow), 0);
    chk("t3 head", 32'(rd_data), 32'h0100A);
    chk("t3 pc", 32'(press_count), 3);
    step(0, 18'h00001, 1, 0);
    chk("t3 pop1", 32'(rd_data), 32'h0100E);
    step(0, 18'h00001, 1, 0);
    chk("t3 pop2", 32'(rd_data), 32'h01012);
    step(0, 18'h00001, 1, 0);
    chk("t3 newest last", 32'(rd_data), 32'h2BEEF);
    step(0, 18'h00001, 1, 0);
    chk("t3 drained", 32'(level), 0);

    // 4: push 1,2,3 then four back-to-back pops
    tbl[0]  = '{0, 18'h1, 0, 0, 18'h0, 3'd0, 0, 16'd3};
    tbl[1]  = '{0, 18'h1, 0, 0, 18'h0, 3'd0, 0, 16'd3};
    tbl[2]  = '{1, 18'h1, 0, 1, 18'h1, 3'd1, 0, 16'd4};
    tbl[3]  = '{0, 18'h2, 0, 1, 18'h1, 3'd1, 0, 16'd4};
    tbl[4]  = '{0, 18'h2, 0, 1, 18'h1, 3'd1, 0, 16'd4};
    tbl[5]  = '{1, 18'h2, 0, 1, 18'h1, 3'd2, 0, 16'd5};
    tbl[6]  = '{0, 18'h3, 0, 1, 18'h1, 3'd2, 0, 16'd5};
    tbl[7]  = '{0, 18'h3, 0, 1, 18'h1, 3'd2, 0, 16'd5};
    tbl[8]  = '{1, 18'h3, 0, 1, 18'h1, 3'd3, 0, 16'd6};
    tbl[9]  = '{0, 18'h3, 1, 1, 18'h2, 3'd2, 0, 16'd6};
    tbl[10] = '{0, 18'h3, 1, 1, 18'h3, 3'd1, 0, 16'd6};
    tbl[11] = '{0, 18'h3, 1, 0, 18'h0, 3'd0, 0, 16'd6};
    tbl[12] = '{0, 18'h3, 1, 0, 18'h0, 3'd0, 0, 16'd6};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].btn, tbl[i].sw, tbl[i].rd, 0);
      chk($sformatf("t4[%0d] valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("t4[%0d] level", i), 32'(level), 32'(tbl[i].exp_level));
      chk($sformatf("t4[%0d] ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
      chk($sformatf("t4[%0d] pc", i), 32'(press_count), 32'(tbl[i].exp_pc));
      if (tbl[i].exp_valid)
        chk($sformatf("t4[%0d] data", i), 32'(rd_data), 32'(tbl[i].exp_data));
    end

    // 5: release on the cycle the delay timer would fire
    step(0, 18'h3C3C3, 0, 0);
    step(0, 18'h3C3C3, 0, 0);
    step(1, 18'h3C3C3, 0, 0);
    chk("t5 rise level", 32'(level), 1);
    chk("t5 rise pc", 32'(press_count), 7);
    for (int k = 1; k <= 9; k++) step(1, 18'h3C3C3, 0, 0);
    chk("t5 pre-release level", 32'(level), 1);
    step(0, 18'h3C3C3, 0, 0);
    chk("t5 release level", 32'(level), 1);
    step(0, 18'h3C3C3, 0, 0);
    step(0, 18'h3C3C3, 0, 0);
    chk("t5 idle level", 32'(level), 1);
    step(1, 18'h3C3C3, 0, 0);
    chk("t5 re-press level", 32'(level), 2);
    chk("t5 re-press pc", 32'(press_count), 8);
    step(0, 18'h3C3C3, 0, 0);

    // 6: asynchronous reset mid-REPEAT with level 3 and overflow set
    for (int k = 0; k <= 16; k++) step(1, 18'h15555, (k == 15), 0);
    chk("t6 pre level", 32'(level), 3);
    chk("t6 pre ovf", 32'(overflow), 1);
    chk("t6 pre pc", 32'(press_count), 9);
    #2 n_reset = 1'b0;
    #1;
    chk_reset("t6 async");
    button_in = 1'b0;
    #2 n_reset = 1'b1;
    step(0, 18'h0, 0, 0);
    chk("t6 after level", 32'(level), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
